// File: rtl/sm_accumulator.sv
// sm_accumulator: sums groups of sign-magnitude operands and returns a saturated sign-magnitude total per group
module sm_accumulator #(
  parameter int WIDTH = 32,
  parameter int GUARD = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_sat,
  output logic [CNT_W-1:0] out_count,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int AW = WIDTH + GUARD;
  localparam int MW = WIDTH - 1;
  typedef enum logic {ACCUM, DRAIN} state_t;
  state_t state;
  logic [AW-1:0] acc, mag, op, sum, abs_sum;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic wov, wov_sign, ovf, wov_n, wsign_n, neg, big;
  logic [WIDTH-1:0] res;
  assign mag = {{(GUARD+1){1'b0}}, in_data[MW-1:0]};
  assign in_ready = (state == ACCUM);
  assign out_valid = (state == DRAIN);
  always_comb begin
    op = in_data[MW] ? -mag : mag;
    sum = acc + op;
    ovf = (acc[AW-1] == op[AW-1]) && (sum[AW-1] != acc[AW-1]);
    wov_n = wov | ovf;
    wsign_n = wov ? wov_sign : op[AW-1];
    cnt_n = &cnt ? cnt : cnt + 1'b1;
    neg = sum[AW-1];
    abs_sum = neg ? -sum : sum;
    big = |abs_sum[AW-1:MW];
    res = wov_n ? {wsign_n, {MW{1'b1}}} : big ? {neg, {MW{1'b1}}} : {neg, abs_sum[MW-1:0]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      acc <= '0;
      cnt <= '0;
      wov <= 1'b0;
      wov_sign <= 1'b0;
      out_sum <= '0;
      out_sat <= 1'b0;
      out_count <= '0;
    end else if (state == ACCUM) begin
      if (in_valid && in_last) begin
        state <= DRAIN;
        out_sum <= res;
        out_sat <= wov_n | big;
        out_count <= cnt_n;
        acc <= '0;
        cnt <= '0;
        wov <= 1'b0;
        wov_sign <= 1'b0;
      end else if (in_valid) begin
        acc <= sum;
        cnt <= cnt_n;
        wov <= wov_n;
        wov_sign <= wsign_n;
      end
    end else if (out_ready) begin
      state <= ACCUM;
    end
  end
endmodule

// File: tb/tb_sm_accumulator.sv
// tb_sm_accumulator: directed self-checking bench for sm_accumulator
module tb_sm_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic in_ready;
  logic [31:0] out_sum;
  logic out_sat;
  logic [15:0] out_count;
  logic out_valid;
  logic out_ready = 1'b0;
  int checks = 0;
  int errors = 0;

  sm_accumulator dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_sum(out_sum), .out_sat(out_sat), .out_count(out_count),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic l);
    @(negedge clk);
    in_data = d;
    in_valid = 1'b1;
    in_last = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic get(input string tag, input logic [31:0] s, input logic sat, input logic [15:0] c);
    @(negedge clk);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_sum"}, 64'(out_sum), 64'(s));
    chk({tag, "_sat"}, 64'(out_sat), 64'(sat));
    chk({tag, "_count"}, 64'(out_count), 64'(c));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_sum"}, 64'(out_sum), 64'd0);
    chk({tag, "_sat"}, 64'(out_sat), 64'd0);
    chk({tag, "_count"}, 64'(out_count), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset("reset");

    beat(32'h00000005, 0);
    beat(32'h00000007, 1);
    get("pos", 32'h0000000C, 0, 2);

    beat(32'h80000003, 0);
    beat(32'h80000005, 1);
    get("negneg", 32'h80000008, 0, 2);

    beat(32'h00000002, 0);
    beat(32'h80000003, 1);
    get("mix_neg", 32'h80000001, 0, 2);

    beat(32'h00000003, 0);
    beat(32'h80000003, 1);
    get("mix_zero", 32'h00000000, 0, 2);

    beat(32'h7FFFFFFF, 0);
    beat(32'h00000001, 1);
    get("sat_pos", 32'h7FFFFFFF, 1, 2);

    beat(32'hFFFFFFFF, 0);
    beat(32'h80000002, 1);
    get("sat_neg", 32'hFFFFFFFF, 1, 2);

    // total is 2^32-4, beyond full scale, so it clamps
    beat(32'h7FFFFFFF, 0);
    beat(32'h7FFFFFFF, 0);
    beat(32'h80000001, 0);
    beat(32'h80000001, 1);
    get("sat_four", 32'h7FFFFFFF, 1, 4);

    // intermediate 2^32-2 lives in the guard bits; final total fits
    beat(32'h7FFFFFFF, 0);
    beat(32'h7FFFFFFF, 0);
    beat(32'hFFFFFFFF, 1);
    get("guard", 32'h7FFFFFFF, 0, 3);

    // 257 full-scale positives wrap the 40-bit accumulator negative
    for (int i = 0; i < 257; i++) beat(32'h7FFFFFFF, 0);
    beat(32'h00000001, 1);
    get("wrap", 32'h7FFFFFFF, 1, 258);

    beat(32'h00000011, 0);
    beat(32'h00000022, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_data = 32'h00000100;
      in_valid = 1'b1;
      in_last = 1'b1;
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_sum", 64'(out_sum), 64'h33);
      chk("bp_count", 64'(out_count), 64'd2);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    get("bp", 32'h00000033, 0, 2);
    beat(32'h00000002, 1);
    get("after_bp", 32'h00000002, 0, 1);

    out_ready = 1'b1;
    beat(32'h80000000, 1);
    @(negedge clk);
    chk("b2b1_valid", 64'(out_valid), 64'd1);
    chk("b2b1_sum", 64'(out_sum), 64'h0);
    chk("b2b1_count", 64'(out_count), 64'd1);
    beat(32'h00000009, 1);
    @(negedge clk);
    chk("b2b2_valid", 64'(out_valid), 64'd1);
    chk("b2b2_sum", 64'(out_sum), 64'h9);
    chk("b2b2_count", 64'(out_count), 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    beat(32'h00000004, 0);
    beat(32'h00000006, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset("midrst");
    beat(32'h00000001, 1);
    get("after_rst", 32'h00000001, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
